// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction-fetch
// and load/store requesters, with registered issue, response pulse and timeout abort.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   // instruction-fetch requester
   input  logic                  i_request,
   input  logic                  i_we_re,
   input  logic [3:0]            i_mask,
   input  logic [ADDR_WIDTH-1:0] i_address,
   input  logic [DATA_WIDTH-1:0] i_data_in,
   output logic                  i_valid,
   output logic                  i_error,
   output logic [DATA_WIDTH-1:0] i_data_out,
   // load/store requester
   input  logic                  d_request,
   input  logic                  d_we_re,
   input  logic [3:0]            d_mask,
   input  logic [ADDR_WIDTH-1:0] d_address,
   input  logic [DATA_WIDTH-1:0] d_data_in,
   output logic                  d_valid,
   output logic                  d_error,
   output logic [DATA_WIDTH-1:0] d_data_out,
   // shared memory
   output logic                  m_request,
   output logic                  m_we_re,
   output logic [3:0]            m_mask,
   output logic [ADDR_WIDTH-1:0] m_address,
   output logic [DATA_WIDTH-1:0] m_data_in,
   input  logic                  m_valid,
   input  logic [DATA_WIDTH-1:0] m_data_out,
   output logic                  busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_next_state;
   logic [15:0]   r_count;
   logic          r_grant_d;     // 1 = data side holds (or last held) the grant
   logic          w_grant_d;
   logic          w_start;
   logic          w_done_ok;
   logic          w_timeout;

   // NOTE: every signal driven here gets a default first so no path leaves it
   // unassigned; otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      w_next_state = r_state;
      w_grant_d    = r_grant_d;
      w_start      = 1'b0;
      w_done_ok    = 1'b0;
      w_timeout    = 1'b0;

      if (i_request && d_request)
         w_grant_d = ~r_grant_d;
      else if (d_request)
         w_grant_d = 1'b1;
      else if (i_request)
         w_grant_d = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (i_request || d_request) begin
               w_start      = 1'b1;
               w_next_state = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (m_valid) begin
               w_done_ok    = 1'b1;
               w_next_state = ST_RESP;
            end else if (r_count == 16'(TIMEOUT - 1)) begin
               w_timeout    = 1'b1;
               w_next_state = ST_RESP;
            end
         end
         ST_RESP:  w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_next_state;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_grant_d  <= 1'b1;
         r_count    <= '0;
         m_request  <= 1'b0;
         m_we_re    <= 1'b0;
         m_mask     <= '0;
         m_address  <= '0;
         m_data_in  <= '0;
         i_valid    <= 1'b0;
         i_error    <= 1'b0;
         i_data_out <= '0;
         d_valid    <= 1'b0;
         d_error    <= 1'b0;
         d_data_out <= '0;
         busy       <= 1'b0;
      end else begin
         i_valid <= 1'b0;
         i_error <= 1'b0;
         d_valid <= 1'b0;
         d_error <= 1'b0;
         busy    <= (w_next_state != ST_IDLE);

         if (w_start) begin
            r_grant_d <= w_grant_d;
            r_count   <= '0;
            m_request <= 1'b1;
            if (w_grant_d) begin
               m_we_re   <= d_we_re;
               m_mask    <= d_mask;
               m_address <= d_address;
               m_data_in <= d_data_in;
            end else begin
               m_we_re   <= i_we_re;
               m_mask    <= i_mask;
               m_address <= i_address;
               m_data_in <= i_data_in;
            end
         end else if (r_state == ST_BUSY) begin
            r_count <= r_count + 16'd1;
            if (w_done_ok || w_timeout) begin
               m_request <= 1'b0;
               // a timed-out transaction returns zero data alongside the error flag
               if (r_grant_d) begin
                  d_valid    <= 1'b1;
                  d_error    <= w_timeout;
                  d_data_out <= w_timeout ? '0 : m_data_out;
               end else begin
                  i_valid    <= 1'b1;
                  i_error    <= w_timeout;
                  i_data_out <= w_timeout ? '0 : m_data_out;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=4): reset, round-robin ties,
// read/write pass-through, timeout abort, m_valid/timeout precedence, mid-flight reset.
module tb_mem_port_arbiter;

   localparam int AW = 8;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_request = 1'b0, i_we_re = 1'b0;
   logic [3:0]    i_mask = '0;
   logic [AW-1:0] i_address = '0;
   logic [DW-1:0] i_data_in = '0;
   logic          i_valid, i_error;
   logic [DW-1:0] i_data_out;
   logic          d_request = 1'b0, d_we_re = 1'b0;
   logic [3:0]    d_mask = '0;
   logic [AW-1:0] d_address = '0;
   logic [DW-1:0] d_data_in = '0;
   logic          d_valid, d_error;
   logic [DW-1:0] d_data_out;
   logic          m_request, m_we_re;
   logic [3:0]    m_mask;
   logic [AW-1:0] m_address;
   logic [DW-1:0] m_data_in;
   logic          m_valid = 1'b0;
   logic [DW-1:0] m_data_out = '0;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;

   mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .i_request(i_request), .i_we_re(i_we_re), .i_mask(i_mask),
      .i_address(i_address), .i_data_in(i_data_in),
      .i_valid(i_valid), .i_error(i_error), .i_data_out(i_data_out),
      .d_request(d_request), .d_we_re(d_we_re), .d_mask(d_mask),
      .d_address(d_address), .d_data_in(d_data_in),
      .d_valid(d_valid), .d_error(d_error), .d_data_out(d_data_out),
      .m_request(m_request), .m_we_re(m_we_re), .m_mask(m_mask),
      .m_address(m_address), .m_data_in(m_data_in),
      .m_valid(m_valid), .m_data_out(m_data_out),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance one clock; outputs are sampled 1 ns after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " m_request"}, 32'(m_request), 32'd0);
      check({tag, " m_fields"}, {m_we_re, m_mask, m_address}, 32'd0);
      check({tag, " m_data_in"}, m_data_in, 32'd0);
      check({tag, " valids"}, {i_valid, i_error, d_valid, d_error}, 32'd0);
      check({tag, " i_data_out"}, i_data_out, 32'd0);
      check({tag, " d_data_out"}, d_data_out, 32'd0);
      check({tag, " busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      // ---------------- reset state ----------------
      step();
      check_all_zero("reset");
      rst = 1'b0;
      step();
      check("idle busy", 32'(busy), 32'd0);

      // ---------------- tie round-robin: I, D, I, D ----------------
      i_address = 8'hA1;
      d_address = 8'hD1;
      i_request = 1'b1;
      d_request = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         check("rr m_request", 32'(m_request), 32'd1);
         check("rr m_address", 32'(m_address), (k % 2 == 0) ? 32'hA1 : 32'hD1);
         m_valid    = 1'b1;
         m_data_out = 32'h0000_1000 + 32'(k);
         step();
         check("rr valid", {30'd0, i_valid, d_valid}, (k % 2 == 0) ? 32'd2 : 32'd1);
         m_valid = 1'b0;
         step();
         check("rr idle busy", 32'(busy), 32'd0);
      end
      i_request = 1'b0;
      d_request = 1'b0;
      check("rr i_data_out", i_data_out, 32'h0000_1002);
      check("rr d_data_out", d_data_out, 32'h0000_1003);
      step();

      // ---------------- single data read ----------------
      d_request = 1'b1;
      d_address = 8'h10;
      d_we_re   = 1'b0;
      step();
      check("rd m_request", 32'(m_request), 32'd1);
      check("rd m_address", 32'(m_address), 32'h10);
      check("rd m_we_re", 32'(m_we_re), 32'd0);
      check("rd busy", 32'(busy), 32'd1);
      m_valid    = 1'b1;
      m_data_out = 32'hDEADBEEF;
      step();
      check("rd d_valid", 32'(d_valid), 32'd1);
      check("rd d_error", 32'(d_error), 32'd0);
      check("rd d_data_out", d_data_out, 32'hDEADBEEF);
      check("rd i_valid", 32'(i_valid), 32'd0);
      check("rd m_request low", 32'(m_request), 32'd0);
      d_request = 1'b0;
      m_valid   = 1'b0;
      step();
      check("rd back idle", {30'd0, busy, d_valid}, 32'd0);

      // ---------------- instruction write pass-through ----------------
      i_request = 1'b1;
      i_we_re   = 1'b1;
      i_mask    = 4'b0011;
      i_address = 8'h20;
      i_data_in = 32'h12345678;
      step();
      check("wr m_we_re", 32'(m_we_re), 32'd1);
      check("wr m_mask", 32'(m_mask), 32'h3);
      check("wr m_address", 32'(m_address), 32'h20);
      check("wr m_data_in", m_data_in, 32'h12345678);
      i_mask    = 4'hF;
      i_data_in = 32'hFFFF_FFFF;
      step();
      check("wr frozen mask", 32'(m_mask), 32'h3);
      check("wr frozen data", m_data_in, 32'h12345678);
      check("wr held m_request", 32'(m_request), 32'd1);
      m_valid    = 1'b1;
      m_data_out = 32'hCAFE0001;
      step();
      check("wr i_valid", {30'd0, i_valid, i_error}, 32'd2);
      check("wr i_data_out", i_data_out, 32'hCAFE0001);
      check("wr d_valid", 32'(d_valid), 32'd0);
      check("wr d_data_out held", d_data_out, 32'hDEADBEEF);
      i_request = 1'b0;
      i_we_re   = 1'b0;
      m_valid   = 1'b0;
      step();

      // ---------------- timeout (TIMEOUT=4) ----------------
      d_request = 1'b1;
      d_address = 8'h30;
      for (int k = 0; k < 4; k++) begin
         step();
         check("to m_request high", 32'(m_request), 32'd1);
         check("to no valid", 32'(d_valid), 32'd0);
      end
      step();
      check("to m_request low", 32'(m_request), 32'd0);
      check("to d_valid", 32'(d_valid), 32'd1);
      check("to d_error", 32'(d_error), 32'd1);
      check("to d_data_out", d_data_out, 32'd0);
      d_request = 1'b0;
      step();
      check("to idle", {30'd0, busy, d_valid}, 32'd0);

      i_request = 1'b1;
      i_address = 8'h40;
      step();
      check("post-to m_request", 32'(m_request), 32'd1);
      check("post-to m_address", 32'(m_address), 32'h40);
      m_valid    = 1'b1;
      m_data_out = 32'h11112222;
      step();
      check("post-to i_valid", {30'd0, i_valid, i_error}, 32'd2);
      check("post-to i_data_out", i_data_out, 32'h11112222);
      i_request = 1'b0;
      m_valid   = 1'b0;
      step();

      // ---------------- m_valid on the last allowed BUSY cycle ----------------
      d_request = 1'b1;
      d_address = 8'h50;
      step();
      step();
      step();
      step();
      check("edge m_request", 32'(m_request), 32'd1);
      m_valid    = 1'b1;
      m_data_out = 32'h55AA55AA;
      step();
      check("edge d_valid", 32'(d_valid), 32'd1);
      check("edge d_error", 32'(d_error), 32'd0);
      check("edge d_data_out", d_data_out, 32'h55AA55AA);
      d_request  = 1'b0;
      m_data_out = 32'h0BAD0BAD;   // stray m_valid stays high through RESP and IDLE
      step();
      check("stray resp", {29'd0, busy, d_valid, i_valid}, 32'd0);
      check("stray resp m_request", 32'(m_request), 32'd0);
      step();
      check("stray idle", {29'd0, busy, d_valid, i_valid}, 32'd0);
      check("stray idle data", d_data_out, 32'h55AA55AA);
      m_valid = 1'b0;

      // ---------------- asynchronous reset mid-BUSY ----------------
      i_request = 1'b1;
      i_address = 8'h60;
      step();
      step();
      check("pre-rst m_request", 32'(m_request), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("async rst");
      i_request = 1'b0;
      m_valid   = 1'b1;
      step();
      step();
      rst     = 1'b0;
      m_valid = 1'b0;
      step();
      check("post-rst no valid", {30'd0, i_valid, d_valid}, 32'd0);
      check("post-rst m_request", 32'(m_request), 32'd0);
      i_request = 1'b1;
      step();
      check("post-rst issue", 32'(m_request), 32'd1);
      check("post-rst m_address", 32'(m_address), 32'h60);
      m_valid    = 1'b1;
      m_data_out = 32'h600D600D;
      step();
      check("post-rst i_valid", 32'(i_valid), 32'd1);
      check("post-rst i_data_out", i_data_out, 32'h600D600D);
      i_request = 1'b0;
      m_valid   = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
